mac_tx_crc_fifo: RTL and testbench

MAC_TX_CRC_FIFO -- requirements
Module: mac_tx_crc_fifo

---
 rtl/mac_tx_crc_fifo_pkg.sv | 16 +
 rtl/mac_crc32_engine.sv | 53 +++++
 rtl/mac_tx_crc_fifo.sv | 86 ++++++++
 tb/tb_mac_tx_crc_fifo.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_tx_crc_fifo_pkg.sv
// Shared constants and types for the MAC transmit FIFO and its Ethernet FCS engine.
package mac_tx_crc_fifo_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CRC_W  = 32;

    localparam logic [CRC_W-1:0] CRC32_POLY_REFL = 32'hEDB8_8320;
    localparam logic [CRC_W-1:0] CRC32_SEED      = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        CRC_SEED  = 2'd0,
        CRC_ACCUM = 2'd1,
        CRC_HOLD  = 2'd2
    } crc_op_e;

endpackage

// File: rtl/mac_crc32_engine.sv
// Byte-wide reflected CRC-32 engine; crc_out is the ready-to-send FCS (first byte in [7:0]).
module mac_crc32_engine
    import mac_tx_crc_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              crc_init,
    input  logic              crc_en,
    output logic [CRC_W-1:0]  crc_out
);

    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_d;
    crc_op_e          op_c;

    // One byte of LSB-first CRC-32, bit 0 of data consumed first.
    function automatic logic [CRC_W-1:0] crc32_byte(input logic [CRC_W-1:0] crc,
                                                   input logic [BYTE_W-1:0] data);
        logic [CRC_W-1:0] c;
        c = crc;
        for (int i = 0; i < int'(BYTE_W); i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY_REFL;
            else                c = c >> 1;
        end
        return c;
    endfunction

    // Freeze wins over accumulate; idle cycles reseed so each frame restarts cleanly.
    always_comb begin
        op_c = CRC_SEED;
        if (crc_en)        op_c = CRC_HOLD;
        else if (crc_init) op_c = CRC_ACCUM;
    end

    always_comb begin
        crc_d = crc_q;
        unique case (op_c)
            CRC_SEED:  crc_d = CRC32_SEED;
            CRC_ACCUM: crc_d = crc32_byte(crc_q, data_in);
            CRC_HOLD:  crc_d = crc_q;
            default:   crc_d = CRC32_SEED;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) crc_q <= CRC32_SEED;
        else      crc_q <= crc_d;
    end

    assign crc_out = ~crc_q;

endmodule

// File: rtl/mac_tx_crc_fifo.sv
// MAC transmit byte FIFO with an attached Ethernet FCS engine.
module mac_tx_crc_fifo
    import mac_tx_crc_fifo_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2048,
    parameter int unsigned ADDR_W     = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] tx_fifo_wr_data,
    input  logic              tx_fifo_wr_en,
    input  logic              tx_fifo_rd_en,
    output logic [BYTE_W-1:0] tx_fifo_rd_data,
    output logic              tx_fifo_full,
    output logic              tx_fifo_empty,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              crc_init,
    input  logic              crc_en,
    output logic [CRC_W-1:0]  crc_out
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [BYTE_W-1:0] mem [FIFO_DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [BYTE_W-1:0] rd_data_q, rd_data_d;
    logic              wr_acc_c;
    logic              rd_acc_c;

    assign tx_fifo_full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign tx_fifo_empty   = (count_q == '0);
    assign tx_fifo_rd_data = rd_data_q;

    // Full blocks writes and empty blocks reads, which settles every simultaneous case.
    assign wr_acc_c = tx_fifo_wr_en && !tx_fifo_full;
    assign rd_acc_c = tx_fifo_rd_en && !tx_fifo_empty;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        if (wr_acc_c) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (rd_acc_c) begin
            rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
            rd_data_d = mem[rd_ptr_q];
        end
        case ({wr_acc_c, rd_acc_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc_c) mem[wr_ptr_q] <= tx_fifo_wr_data;
    end

    mac_crc32_engine u_crc (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .crc_init (crc_init),
        .crc_en   (crc_en),
        .crc_out  (crc_out)
    );

endmodule

// File: tb/tb_mac_tx_crc_fifo.sv
// Scoreboard bench for mac_tx_crc_fifo: queue-based FIFO model and table-driven CRC-32 model.
module tb_mac_tx_crc_fifo;

    localparam int unsigned DEPTH = 2048;

    localparam int K_RD    = 0;
    localparam int K_EMPTY = 1;
    localparam int K_FULL  = 2;
    localparam int K_CRC   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  tx_fifo_wr_data = '0;
    logic        tx_fifo_wr_en = 1'b0;
    logic        tx_fifo_rd_en = 1'b0;
    logic [7:0]  tx_fifo_rd_data;
    logic        tx_fifo_full;
    logic        tx_fifo_empty;
    logic [7:0]  data_in = '0;
    logic        crc_init = 1'b0;
    logic        crc_en = 1'b0;
    logic [31:0] crc_out;

    mac_tx_crc_fifo #(.FIFO_DEPTH(DEPTH), .ADDR_W(11)) dut (
        .clk             (clk),
        .rst             (rst),
        .tx_fifo_wr_data (tx_fifo_wr_data),
        .tx_fifo_wr_en   (tx_fifo_wr_en),
        .tx_fifo_rd_en   (tx_fifo_rd_en),
        .tx_fifo_rd_data (tx_fifo_rd_data),
        .tx_fifo_full    (tx_fifo_full),
        .tx_fifo_empty   (tx_fifo_empty),
        .data_in         (data_in),
        .crc_init        (crc_init),
        .crc_en          (crc_en),
        .crc_out         (crc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference state
    logic [7:0]  m_q[$];
    logic [7:0]  m_last;
    logic [31:0] m_r;
    logic [31:0] crc_tab[256];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push_exp(input int kind, input logic [31:0] val, input string name);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_last = 8'h00;
        m_r    = 32'hFFFF_FFFF;
    endfunction

    // Drive one clock's worth of inputs, advance the model, and queue what the DUT must show after the edge.
    task automatic cycle(input logic wr, input logic [7:0] wd, input logic rd,
                         input logic ci, input logic ce, input logic [7:0] cd);
        bit was_empty;
        bit was_full;
        @(negedge clk);
        tx_fifo_wr_en   = wr;
        tx_fifo_wr_data = wd;
        tx_fifo_rd_en   = rd;
        crc_init        = ci;
        crc_en          = ce;
        data_in         = cd;
        was_empty = (m_q.size() == 0);
        was_full  = (m_q.size() == DEPTH);
        if (rd && !was_empty) m_last = m_q.pop_front();
        if (wr && !was_full)  m_q.push_back(wd);
        if (ce)      m_r = m_r;
        else if (ci) m_r = (m_r >> 8) ^ crc_tab[m_r[7:0] ^ cd];
        else         m_r = 32'hFFFF_FFFF;
        push_exp(K_RD,    32'(m_last), "rd_data");
        push_exp(K_EMPTY, 32'(m_q.size() == 0), "empty");
        push_exp(K_FULL,  32'(m_q.size() == DEPTH), "full");
        push_exp(K_CRC,   ~m_r, "crc_out");
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("rst_empty",   32'(tx_fifo_empty),   32'd1);
        check("rst_full",    32'(tx_fifo_full),    32'd0);
        check("rst_rd_data", 32'(tx_fifo_rd_data), 32'd0);
        check("rst_crc_out", crc_out,              32'd0);
        model_reset();
        tx_fifo_wr_en = 1'b0;
        tx_fifo_rd_en = 1'b0;
        crc_init      = 1'b0;
        crc_en        = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic crc_frame_123456789();
        for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'(8'h31 + i));
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b0, $urandom_range(0, 1) == 1, 1'b1, 8'($urandom));
            push_exp(K_CRC, 32'hCBF4_3926, "crc_check_value");
        end
    endtask

    // Monitor: after every rising edge, retire everything the driver queued for it.
    exp_t mon_e;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                case (mon_e.kind)
                    K_RD:    check(mon_e.name, 32'(tx_fifo_rd_data), mon_e.val);
                    K_EMPTY: check(mon_e.name, 32'(tx_fifo_empty),   mon_e.val);
                    K_FULL:  check(mon_e.name, 32'(tx_fifo_full),    mon_e.val);
                    default: check(mon_e.name, crc_out,              mon_e.val);
                endcase
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] c;
        for (int n = 0; n < 256; n++) begin
            c = 32'(n);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            crc_tab[n] = c;
        end
        model_reset();

        do_reset();

        // Known-answer CRC, then reseed for one idle cycle and repeat
        crc_frame_123456789();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        push_exp(K_CRC, 32'h0000_0000, "crc_seeded");
        crc_frame_123456789();

        // Three writes, four reads; the extra read must leave the last byte in place
        cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        push_exp(K_RD, 32'h11, "rd_first");
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        push_exp(K_RD, 32'h22, "rd_second");
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        push_exp(K_RD, 32'h33, "rd_third");
        push_exp(K_EMPTY, 32'd1, "empty_after_three");
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        push_exp(K_RD, 32'h33, "rd_hold_when_empty");

        // Read+write while empty: only the write lands
        cycle(1'b1, 8'h5C, 1'b1, 1'b0, 1'b0, 8'h00);
        push_exp(K_RD, 32'h33, "rd_unchanged_on_empty_rw");
        push_exp(K_EMPTY, 32'd0, "count_one_after_empty_rw");
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        push_exp(K_RD, 32'h5C, "rd_after_empty_rw");

        // Two fill/drain passes, the second starting from non-zero pointers
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < int'(DEPTH); i++)
                cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, 8'h00);
            push_exp(K_FULL, 32'd1, "full_after_fill");
            cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00);
            push_exp(K_FULL, 32'd1, "full_after_dropped_write");
            cycle(1'b1, 8'hAB, 1'b1, 1'b0, 1'b0, 8'h00);
            push_exp(K_FULL, 32'd0, "full_rw_reads_only");
            for (int i = 0; i < int'(DEPTH); i++)
                cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
            push_exp(K_EMPTY, 32'd1, "empty_after_drain");
        end

        // Random traffic, write-heavy then read-heavy, with random CRC control
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 1500; i++)
                cycle($urandom_range(0, 99) < (ph == 0 ? 70 : 30), 8'($urandom),
                      $urandom_range(0, 99) < (ph == 0 ? 40 : 70),
                      $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 15, 8'($urandom));
        end

        // Reset in the middle of a frame and a partly filled FIFO
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0, 8'($urandom));
        do_reset();
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        push_exp(K_EMPTY, 32'd1, "empty_after_mid_reset");
        push_exp(K_RD, 32'h00, "rd_after_mid_reset");
        crc_frame_123456789();

        @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
